// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the RAM port-1 arbiter.
package ram_arb_pkg;

  typedef enum logic [1:0] {S_IDLE, S_OWN0, S_OWN1} arb_state_t;

  typedef logic master_id_t;

  localparam int CONFLICT_W = 16;

  function automatic arb_state_t own_state(input master_id_t id);
    return id ? S_OWN1 : S_OWN0;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Per-master request/ready access bus into the RAM port arbiter.
interface ram_port_arbiter_if #(
  parameter int W  = 32,
  parameter int AW = 7
);

  logic          req;
  logic          lock;
  logic          wr_ena;
  logic [AW-1:0] addr;
  logic [W-1:0]  wr_data;
  logic          ready;
  logic [W-1:0]  rd_data;

  modport master (output req, lock, wr_ena, addr, wr_data, input ready, rd_data);
  modport slave  (input req, lock, wr_ena, addr, wr_data, output ready, rd_data);

endinterface

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [N-1:0] count
);

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != {N{1'b1}})) begin
      count <= count + N'(1);
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter with bounded burst lock sharing RAM port 1 between two masters.
// Optional contention counter enabled by defining RAM_ARB_CONFLICT_CNT_EN.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int W        = 32,
  parameter int L        = 128,
  parameter int MAX_LOCK = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  ram_port_arbiter_if.slave     m0,
  ram_port_arbiter_if.slave     m1,
  output logic                  ram_wr_ena,
  output logic [$clog2(L)-1:0]  ram_addr,
  output logic [W-1:0]          ram_wr_data,
  input  logic [W-1:0]          ram_rd_data,
  output logic [CONFLICT_W-1:0] conflict_cnt
);

  localparam int AW  = $clog2(L);
  localparam int LCW = $clog2(MAX_LOCK + 1);
  localparam logic [LCW-1:0] LOCK_LAST = LCW'(MAX_LOCK - 1);

  arb_state_t     state, state_nxt;
  master_id_t     rr_last, rr_last_nxt;
  logic [LCW-1:0] lock_cnt, lock_cnt_nxt;

  master_id_t    owner;
  logic          owning;
  logic          own_req, own_lock, own_wr, oth_req;
  logic [AW-1:0] own_addr;
  logic [W-1:0]  own_wdata;

  assign owning    = (state == S_OWN0) || (state == S_OWN1);
  assign owner     = (state == S_OWN1);
  assign own_req   = owner ? m1.req     : m0.req;
  assign own_lock  = owner ? m1.lock    : m0.lock;
  assign own_wr    = owner ? m1.wr_ena  : m0.wr_ena;
  assign own_addr  = owner ? m1.addr    : m0.addr;
  assign own_wdata = owner ? m1.wr_data : m0.wr_data;
  assign oth_req   = owner ? m0.req     : m1.req;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      rr_last  <= 1'b1;
      lock_cnt <= '0;
    end else begin
      state    <= state_nxt;
      rr_last  <= rr_last_nxt;
      lock_cnt <= lock_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    rr_last_nxt  = rr_last;
    lock_cnt_nxt = lock_cnt;
    case (state)
      S_IDLE: begin
        lock_cnt_nxt = '0;
        if (m0.req && m1.req) begin
          state_nxt = own_state(!rr_last);
        end else if (m0.req) begin
          state_nxt = S_OWN0;
        end else if (m1.req) begin
          state_nxt = S_OWN1;
        end
      end
      S_OWN0, S_OWN1: begin
        // Lock extends ownership; otherwise a waiting peer always wins the next slot.
        if (own_req && own_lock && (lock_cnt < LOCK_LAST)) begin
          lock_cnt_nxt = lock_cnt + LCW'(1);
        end else if (oth_req) begin
          state_nxt    = own_state(!owner);
          rr_last_nxt  = owner;
          lock_cnt_nxt = '0;
        end else if (own_req) begin
          lock_cnt_nxt = '0;
        end else begin
          state_nxt    = S_IDLE;
          lock_cnt_nxt = '0;
        end
      end
      default: begin
        state_nxt    = S_IDLE;
        lock_cnt_nxt = '0;
      end
    endcase
  end

  assign m0.ready   = !rst && (state == S_OWN0) && m0.req;
  assign m1.ready   = !rst && (state == S_OWN1) && m1.req;
  assign m0.rd_data = m0.ready ? ram_rd_data : '0;
  assign m1.rd_data = m1.ready ? ram_rd_data : '0;

  assign ram_wr_ena  = own_wr && (m0.ready || m1.ready);
  assign ram_addr    = (owning && !rst) ? own_addr  : '0;
  assign ram_wr_data = (owning && !rst) ? own_wdata : '0;

`ifdef RAM_ARB_CONFLICT_CNT_EN
  logic                  contested;
  logic [CONFLICT_W-1:0] conflict_q;

  assign contested = m0.req && m1.req && !(m0.ready && m1.ready);

  sat_counter #(.N(CONFLICT_W)) u_conflict (
    .clk   (clk),
    .clr   (rst),
    .inc   (contested),
    .count (conflict_q)
  );

  assign conflict_cnt = rst ? '0 : conflict_q;
`else
  assign conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed vector bench for ram_port_arbiter with a behavioural async-read RAM on port 1.
module tb_ram_port_arbiter;
  import ram_arb_pkg::*;

  localparam int W        = 32;
  localparam int L        = 128;
  localparam int AW       = 7;
  localparam int MAX_LOCK = 4;
`ifdef RAM_ARB_CONFLICT_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  mem_clr;
  logic                  ram_wr_ena;
  logic [AW-1:0]         ram_addr;
  logic [W-1:0]          ram_wr_data;
  logic [W-1:0]          ram_rd_data;
  logic [CONFLICT_W-1:0] conflict_cnt;
  logic [W-1:0]          mem [L];
  int                    total  = 0;
  int                    passed = 0;

  ram_port_arbiter_if #(.W(W), .AW(AW)) m0_if ();
  ram_port_arbiter_if #(.W(W), .AW(AW)) m1_if ();

  always #5 clk = ~clk;

  ram_port_arbiter #(.W(W), .L(L), .MAX_LOCK(MAX_LOCK)) dut (
    .clk          (clk),
    .rst          (rst),
    .m0           (m0_if),
    .m1           (m1_if),
    .ram_wr_ena   (ram_wr_ena),
    .ram_addr     (ram_addr),
    .ram_wr_data  (ram_wr_data),
    .ram_rd_data  (ram_rd_data),
    .conflict_cnt (conflict_cnt)
  );

  always_ff @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < L; i++) mem[i] <= '0;
    end else if (ram_wr_ena) begin
      mem[ram_addr] <= ram_wr_data;
    end
  end

  assign ram_rd_data = mem[ram_addr];

  // Control fields pack {req, lock, wr_ena}; rdy packs {m0_ready, m1_ready}.
  typedef struct {
    string         name;
    logic          rst;
    logic [2:0]    c0;
    logic [AW-1:0] a0;
    logic [W-1:0]  d0;
    logic [2:0]    c1;
    logic [AW-1:0] a1;
    logic [W-1:0]  d1;
    logic [1:0]    rdy;
    logic          wr;
    logic [AW-1:0] addr;
    logic [W-1:0]  wd;
    logic [W-1:0]  rd0;
    logic [W-1:0]  rd1;
    logic [15:0]   cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic void addVec(input string n, input logic r,
                                 input logic [2:0] c0, input logic [AW-1:0] a0, input logic [W-1:0] d0,
                                 input logic [2:0] c1, input logic [AW-1:0] a1, input logic [W-1:0] d1,
                                 input logic [1:0] rdy, input logic wr, input logic [AW-1:0] addr,
                                 input logic [W-1:0] wd, input logic [W-1:0] rd0, input logic [W-1:0] rd1,
                                 input logic [15:0] cnt);
    vec_t v;
    v.name = n;   v.rst = r;
    v.c0 = c0;    v.a0 = a0;     v.d0 = d0;
    v.c1 = c1;    v.a1 = a1;     v.d1 = d1;
    v.rdy = rdy;  v.wr = wr;     v.addr = addr;
    v.wd = wd;    v.rd0 = rd0;   v.rd1 = rd1;
    v.cnt = cnt;
    vecs.push_back(v);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    rst            = v.rst;
    m0_if.req      = v.c0[2];
    m0_if.lock     = v.c0[1];
    m0_if.wr_ena   = v.c0[0];
    m0_if.addr     = v.a0;
    m0_if.wr_data  = v.d0;
    m1_if.req      = v.c1[2];
    m1_if.lock     = v.c1[1];
    m1_if.wr_ena   = v.c1[0];
    m1_if.addr     = v.a1;
    m1_if.wr_data  = v.d1;
  endtask

  task automatic checkRow(input vec_t v);
    logic [15:0] exp_cnt;
    exp_cnt = CNT_EN ? v.cnt : 16'h0;
    #1;
    checkOutput({v.name, ".m0_ready"}, 32'(m0_if.ready), 32'(v.rdy[1]));
    checkOutput({v.name, ".m1_ready"}, 32'(m1_if.ready), 32'(v.rdy[0]));
    checkOutput({v.name, ".ram_wr_ena"}, 32'(ram_wr_ena), 32'(v.wr));
    checkOutput({v.name, ".ram_addr"}, 32'(ram_addr), 32'(v.addr));
    checkOutput({v.name, ".ram_wr_data"}, ram_wr_data, v.wd);
    checkOutput({v.name, ".m0_rd_data"}, m0_if.rd_data, v.rd0);
    checkOutput({v.name, ".m1_rd_data"}, m1_if.rd_data, v.rd1);
    checkOutput({v.name, ".conflict_cnt"}, 32'(conflict_cnt), 32'(exp_cnt));
  endtask

  initial begin
    int   waited;
    int   m1_cnt;
    logic got;

    rst = 1'b1;
    mem_clr = 1'b1;
    m0_if.req = 1'b0; m0_if.lock = 1'b0; m0_if.wr_ena = 1'b0; m0_if.addr = '0; m0_if.wr_data = '0;
    m1_if.req = 1'b0; m1_if.lock = 1'b0; m1_if.wr_ena = 1'b0; m1_if.addr = '0; m1_if.wr_data = '0;

    //     name        rst c0     a0  d0            c1     a1  d1            rdy    wr   addr wd            rd0           rd1           cnt
    addVec("reset",    1, 3'b000, 0, 32'h0,        3'b000, 0, 32'h0,        2'b00, 0,   0, 32'h0,        32'h0,        32'h0,        0);
    addVec("s1_idle",  0, 3'b101, 5, 32'hDEADBEEF, 3'b000, 0, 32'h0,        2'b00, 0,   0, 32'h0,        32'h0,        32'h0,        0);
    addVec("s1_wr",    0, 3'b101, 5, 32'hDEADBEEF, 3'b000, 0, 32'h0,        2'b10, 1,   5, 32'hDEADBEEF, 32'h0,        32'h0,        0);
    addVec("s1_rd",    0, 3'b100, 5, 32'h0,        3'b000, 0, 32'h0,        2'b10, 0,   5, 32'h0,        32'hDEADBEEF, 32'h0,        0);
    addVec("s1_drop",  0, 3'b000, 0, 32'h0,        3'b000, 0, 32'h0,        2'b00, 0,   0, 32'h0,        32'h0,        32'h0,        0);
    addVec("s1_idle2", 0, 3'b000, 0, 32'h0,        3'b000, 0, 32'h0,        2'b00, 0,   0, 32'h0,        32'h0,        32'h0,        0);
    addVec("s2_arb",   0, 3'b100, 5, 32'h0,        3'b101, 9, 32'hA5A5A5A5, 2'b00, 0,   0, 32'h0,        32'h0,        32'h0,        0);
    addVec("s2_g0",    0, 3'b100, 5, 32'h0,        3'b101, 9, 32'hA5A5A5A5, 2'b10, 0,   5, 32'h0,        32'hDEADBEEF, 32'h0,        1);
    addVec("s2_g1",    0, 3'b100, 5, 32'h0,        3'b101, 9, 32'hA5A5A5A5, 2'b01, 1,   9, 32'hA5A5A5A5, 32'h0,        32'h0,        2);
    addVec("s2_g0b",   0, 3'b100, 5, 32'h0,        3'b101, 9, 32'hA5A5A5A5, 2'b10, 0,   5, 32'h0,        32'hDEADBEEF, 32'h0,        3);
    addVec("s2_g1b",   0, 3'b100, 5, 32'h0,        3'b101, 9, 32'hA5A5A5A5, 2'b01, 1,   9, 32'hA5A5A5A5, 32'h0,        32'hA5A5A5A5, 4);
    addVec("s2_drop",  0, 3'b000, 0, 32'h0,        3'b000, 0, 32'h0,        2'b00, 0,   0, 32'h0,        32'h0,        32'h0,        5);
    addVec("s2_idle",  0, 3'b000, 0, 32'h0,        3'b000, 0, 32'h0,        2'b00, 0,   0, 32'h0,        32'h0,        32'h0,        5);
    addVec("s3_arb",   0, 3'b110, 5, 32'h0,        3'b100, 9, 32'h0,        2'b00, 0,   0, 32'h0,        32'h0,        32'h0,        5);
    addVec("s3_lock1", 0, 3'b110, 5, 32'h0,        3'b100, 9, 32'h0,        2'b10, 0,   5, 32'h0,        32'hDEADBEEF, 32'h0,        6);
    addVec("s3_lock2", 0, 3'b110, 5, 32'h0,        3'b100, 9, 32'h0,        2'b10, 0,   5, 32'h0,        32'hDEADBEEF, 32'h0,        7);
    addVec("s3_lock3", 0, 3'b110, 5, 32'h0,        3'b100, 9, 32'h0,        2'b10, 0,   5, 32'h0,        32'hDEADBEEF, 32'h0,        8);
    addVec("s3_lock4", 0, 3'b110, 5, 32'h0,        3'b100, 9, 32'h0,        2'b10, 0,   5, 32'h0,        32'hDEADBEEF, 32'h0,        9);
    addVec("s3_m1",    0, 3'b110, 5, 32'h0,        3'b100, 9, 32'h0,        2'b01, 0,   9, 32'h0,        32'h0,        32'hA5A5A5A5, 10);
    addVec("s3_back",  0, 3'b110, 5, 32'h0,        3'b000, 0, 32'h0,        2'b10, 0,   5, 32'h0,        32'hDEADBEEF, 32'h0,        11);
    addVec("s5_drop",  0, 3'b011, 5, 32'h12345678, 3'b000, 0, 32'h0,        2'b00, 0,   5, 32'h12345678, 32'h0,        32'h0,        11);
    addVec("s5_idle",  0, 3'b100, 5, 32'h0,        3'b000, 0, 32'h0,        2'b00, 0,   0, 32'h0,        32'h0,        32'h0,        11);
    addVec("s5_lat",   0, 3'b100, 5, 32'h0,        3'b000, 0, 32'h0,        2'b10, 0,   5, 32'h0,        32'hDEADBEEF, 32'h0,        11);
    addVec("s5_end",   0, 3'b000, 0, 32'h0,        3'b000, 0, 32'h0,        2'b00, 0,   0, 32'h0,        32'h0,        32'h0,        11);
    addVec("s4_idle",  0, 3'b000, 0, 32'h0,        3'b101, 7, 32'hCAFEF00D, 2'b00, 0,   0, 32'h0,        32'h0,        32'h0,        11);
    addVec("s4_wr",    0, 3'b000, 0, 32'h0,        3'b101, 7, 32'hCAFEF00D, 2'b01, 1,   7, 32'hCAFEF00D, 32'h0,        32'h0,        11);
    addVec("s4_rst",   1, 3'b100, 7, 32'h0,        3'b101, 7, 32'h0BADBEEF, 2'b00, 0,   0, 32'h0,        32'h0,        32'h0,        0);
    addVec("s4_arb",   0, 3'b100, 7, 32'h0,        3'b101, 7, 32'h0BADBEEF, 2'b00, 0,   0, 32'h0,        32'h0,        32'h0,        0);
    addVec("s4_g0",    0, 3'b100, 7, 32'h0,        3'b101, 7, 32'h0BADBEEF, 2'b10, 0,   7, 32'h0,        32'hCAFEF00D, 32'h0,        1);
    addVec("s4_drop",  0, 3'b000, 0, 32'h0,        3'b000, 0, 32'h0,        2'b00, 0,   0, 32'h0,        32'h0,        32'h0,        2);
    addVec("s4_idle2", 0, 3'b000, 0, 32'h0,        3'b000, 0, 32'h0,        2'b00, 0,   0, 32'h0,        32'h0,        32'h0,        2);

    repeat (2) @(negedge clk);
    mem_clr = 1'b0;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkRow(vecs[i]);
    end

    // m1 holds the lock from IDLE; m0 must be served after at most MAX_LOCK+1 waiting cycles.
    got    = 1'b0;
    waited = 0;
    m1_cnt = 0;
    @(negedge clk);
    m0_if.req = 1'b1; m0_if.lock = 1'b0; m0_if.wr_ena = 1'b0; m0_if.addr = 7'd5;
    m1_if.req = 1'b1; m1_if.lock = 1'b1; m1_if.wr_ena = 1'b0; m1_if.addr = 7'd7;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (m0_if.ready) begin
        got = 1'b1;
        break;
      end
      waited++;
      if (m1_if.ready) m1_cnt++;
      @(negedge clk);
    end
    checkOutput("bound.granted", 32'(got), 32'd1);
    checkOutput("bound.wait_cycles", waited, MAX_LOCK + 1);
    checkOutput("bound.m1_burst", m1_cnt, MAX_LOCK);
    checkOutput("bound.m0_rd_data", m0_if.rd_data, 32'hDEADBEEF);

    @(negedge clk);
    m0_if.req = 1'b0; m0_if.lock = 1'b0;
    m1_if.req = 1'b0; m1_if.lock = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("final_rst.m0_ready", 32'(m0_if.ready), 32'd0);
    checkOutput("final_rst.ram_wr_ena", 32'(ram_wr_ena), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
